// File: rtl/rtc_bus_arbiter.sv
// Two-channel request/grant arbiter for the shared 8-bit RTC bus.
// Round-robin on ties, one-cycle turnaround gap, watchdog-forced release.
module rtc_bus_arbiter #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       done0,
    input  logic       done1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] bus_out,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [TMO_W-1:0] WD_ONE  = TMO_W'(1);

    state_t           state, state_nx;
    logic [TMO_W-1:0] wd, wd_nx;
    logic             last_owner, last_owner_nx;
    logic             gnt0_nx, gnt1_nx, timeout_nx;
    logic [7:0]       bus_nx;

    logic [1:0]       req_v, done_v;
    logic [1:0][7:0]  data_v;
    logic             own;
    logic             own_req, own_done, wd_exp;
    logic [7:0]       own_data;

    assign req_v    = {req1, req0};
    assign done_v   = {done1, done0};
    assign data_v   = {data1, data0};

    // Channel index of the current owner; only meaningful in OWN0/OWN1.
    assign own      = (state == OWN1);
    assign own_req  = req_v[own];
    assign own_done = done_v[own];
    assign own_data = data_v[own];
    assign wd_exp   = (wd == WD_LAST);

    assign busy     = (state != IDLE);

    always_comb begin
        state_nx      = state;
        wd_nx         = wd;
        last_owner_nx = last_owner;
        gnt0_nx       = 1'b0;
        gnt1_nx       = 1'b0;
        bus_nx        = 8'h00;
        timeout_nx    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, the channel that did not own the bus last wins.
                if (req0 && (!req1 || last_owner)) begin
                    state_nx      = OWN0;
                    gnt0_nx       = 1'b1;
                    last_owner_nx = 1'b0;
                    wd_nx         = '0;
                end else if (req1) begin
                    state_nx      = OWN1;
                    gnt1_nx       = 1'b1;
                    last_owner_nx = 1'b1;
                    wd_nx         = '0;
                end
            end
            OWN0, OWN1: begin
                if (own_done || !own_req || wd_exp) begin
                    state_nx   = GAP;
                    timeout_nx = !own_done && own_req;
                end else begin
                    gnt0_nx = !own;
                    gnt1_nx = own;
                    bus_nx  = own_data;
                    wd_nx   = wd + WD_ONE;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wd         <= '0;
            last_owner <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            bus_out    <= 8'h00;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            wd         <= wd_nx;
            last_owner <= last_owner_nx;
            gnt0       <= gnt0_nx;
            gnt1       <= gnt1_nx;
            bus_out    <= bus_nx;
            timeout    <= timeout_nx;
        end
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single 8-bit RTC address/data bus between two requesters:
  - channel 0: periodic read/refresh engine.
  - channel 1: user write/config engine.
- Grants exclusive ownership per transaction and drives the owner's byte onto the bus.
- Inserts a turnaround gap between owners and aborts a hung owner by timeout.
- Sits between the two engines and the RTC bus driver. Replaces the zero-detect channel selection with explicit request/grant.

Parameters:
- TMO_W, 8, width of the ownership watchdog counter.
- TMO_MAX, 200, cycles an owner may hold the bus before forced release; must be ≤ 2^TMO_W − 1.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  channel 0 bus request, level; held high for the whole transaction.
- req1  input  1  channel 1 bus request, level.
- done0  input  1  channel 0 end-of-transaction pulse; ignored unless channel 0 owns the bus.
- done1  input  1  channel 1 end-of-transaction pulse; ignored unless channel 1 owns the bus.
- data0  input  8  channel 0 byte for the bus.
- data1  input  8  channel 1 byte for the bus.
- gnt0  output  1  channel 0 owns the bus (registered).
- gnt1  output  1  channel 1 owns the bus (registered).
- bus_out  output  8  byte driven to the RTC bus driver (registered).
- busy  output  1  high whenever state ≠ IDLE.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; gnt0 = gnt1 = 0; bus_out = 8'h00; busy = 0; timeout = 0.
  - watchdog = 0; last_owner = 1, so channel 0 wins the first tie.
- States: IDLE, OWN0, OWN1, GAP.
- IDLE:
  - req0 only → OWN0.
  - req1 only → OWN1.
  - req0 and req1 both high → the channel ≠ last_owner (round robin).
  - Neither → stay.
  - The gnt bit rises on the edge that enters OWNx, i.e. one cycle after the request is first sampled in IDLE.
  - last_owner is updated on entry to OWNx.
- OWNx:
  - Each cycle bus_out <= datax, so bus_out lags datax by 1 cycle.
  - watchdog is cleared on entry and increments each cycle in OWNx.
  - Release conditions, evaluated in priority order; each → GAP:
    - donex = 1
    - reqx = 0 (requester abandon)
    - watchdog == TMO_MAX − 1: force release and pulse timeout for exactly 1 cycle, coincident with the gnt fall.
  - On the release edge: gntx <= 0; bus_out <= 8'h00.
  - Maximum ownership = TMO_MAX cycles of gntx high.
- GAP:
  - Exactly one cycle; gnt0 = gnt1 = 0; bus_out = 8'h00; → IDLE unconditionally.
  - Minimum gap between one gnt falling and the next rising = 2 cycles (GAP + IDLE).
- gnt0 and gnt1 are never high in the same cycle.
- Requests arriving during OWNx or GAP wait; they are not queued beyond their level.
- done of the non-owner, or done while in IDLE/GAP: no effect.
- Simultaneous donex and watchdog expiry: normal release, timeout stays 0.
- Owner's data changing mid-ownership: follows with 1-cycle latency; the other channel's data never reaches bus_out.
- Reset asserted mid-ownership: immediate return to reset values. The requester sees gnt drop asynchronously and must restart.

Test Plan:
- Reset, then req0 = 1, data0 = 8'hA5 at cycle 0 → gnt0 = 1 at cycle 1, bus_out = 8'hA5 from cycle 2; done0 pulse at cycle 5 → gnt0 = 0 and bus_out = 8'h00 at cycle 6, busy = 0 at cycle 7.
- req0 and req1 high together after reset → gnt0 first. After done0, with both requests still high, gnt1 at the next grant (2 cycles after the gnt0 fall). Then gnt0 again, alternating over 4 transactions.
- req1 held with no done1, TMO_MAX = 200 → gnt1 high exactly 200 cycles; timeout one-cycle pulse on the gnt1 fall; next grant issued normally.
- During OWN0, toggle data1 and pulse done1 → bus_out only tracks data0; ownership unchanged.
- req0 dropped at cycle 3 of ownership without done0 → GAP, then IDLE; timeout = 0.
- Reset pulsed while gnt1 = 1 → gnt1, bus_out and busy are 0 immediately. After release with both requests high, channel 0 wins.
